// File: rtl/usb_serial_fifo_pkg.sv
// Shared definitions for the USB-serial FIFO controller: register word
// addresses, STATUS/CTRL bit positions and the RX prefetch state encoding.
package usb_serial_fifo_pkg;

    localparam int unsigned ADR_RX_DATA = 0;
    localparam int unsigned ADR_TX_DATA = 1;
    localparam int unsigned ADR_STATUS  = 2;
    localparam int unsigned ADR_CTRL    = 3;
    localparam int unsigned ADR_TIMEOUT = 4;

    localparam int ST_RX_VALID  = 8;
    localparam int ST_M2U_FULL  = 9;
    localparam int ST_TX_OVF    = 10;
    localparam int ST_RX_PEND   = 11;
    localparam int ST_TX_PEND   = 12;

    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_POP  = 2'd1,
        RX_LOAD = 2'd2,
        RX_HOLD = 2'd3
    } rx_state_e;

    // Expands the four Wishbone byte strobes into a per-bit write mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] bstb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{bstb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/usb_serial_rx_prefetch.sv
// RX prefetch: pops one byte at a time from the USB->M4 FIFO into a holding
// register and counts idle cycles while that byte waits to be read.
module usb_serial_rx_prefetch
    import usb_serial_fifo_pkg::*;
#(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    output logic                 fifo_pop,
    input  logic [7:0]           fifo_dout,
    input  logic [3:0]           popflag,
    input  logic                 consume,
    input  logic [TIMEOUT_W-1:0] timeout,
    output rx_state_e            state,
    output logic [7:0]           rx_byte,
    output logic                 idle_hit
);

    rx_state_e            state_d;
    logic                 rx_valid;
    logic [3:0]           popflag_q;
    logic [TIMEOUT_W-1:0] idle_cnt;

    assign rx_valid = (state == RX_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Pop is only reachable from IDLE, so no second pop can start while a byte is held.
    always_comb begin
        state_d  = state;
        fifo_pop = 1'b0;
        case (state)
            RX_IDLE: if (!fifo_empty) state_d = RX_POP;
            RX_POP: begin
                fifo_pop = 1'b1;
                state_d  = RX_LOAD;
            end
            RX_LOAD: state_d = RX_HOLD;
            RX_HOLD: if (consume) state_d = RX_IDLE;
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_byte   <= 8'd0;
            popflag_q <= 4'd0;
            idle_cnt  <= '0;
        end else begin
            popflag_q <= popflag;
            if (state == RX_LOAD) begin
                rx_byte <= fifo_dout;
            end
            // Any sign of FIFO activity restarts the idle window.
            if (!rx_valid || consume || (popflag != popflag_q)) begin
                idle_cnt <= '0;
            end else if (idle_cnt < timeout) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    assign idle_hit = (timeout != '0) && (idle_cnt == timeout);

endmodule

// File: rtl/usb_serial_fifo_ctrl.sv
// Wishbone slave giving the M4 access to the USB-serial bridge FIFOs:
// RX prefetch, TX push with overflow flag, and a W1C interrupt block.
module usb_serial_fifo_ctrl
    import usb_serial_fifo_pkg::*;
#(
    parameter int             ADDRWIDTH     = 7,
    parameter int             TIMEOUT_W     = 16,
    parameter [TIMEOUT_W-1:0] TIMEOUT_DEF   = 16'd12000,
    parameter [3:0]           RX_THRESH_DEF = 4'h4,
    parameter [3:0]           TX_THRESH_DEF = 4'h4,
    parameter [31:0]          DEF_REG_VALUE = 32'hFAB_DEF_AC
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_n_i,
    input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
    input  logic                 WBs_CYC_i,
    input  logic                 WBs_STB_i,
    input  logic                 WBs_WE_i,
    input  logic [3:0]           WBs_BYTE_STB_i,
    input  logic [31:0]          WBs_DAT_i,
    output logic [31:0]          WBs_DAT_o,
    output logic                 WBs_ACK_o,
    output logic                 FIFO_u2m_pop,
    input  logic [7:0]           FIFO_u2m_dout,
    input  logic                 FIFO_u2m_empty,
    input  logic [3:0]           FIFO_u2m_popflag,
    output logic                 FIFO_m2u_push,
    output logic [7:0]           FIFO_m2u_din,
    input  logic                 FIFO_m2u_full,
    input  logic [3:0]           FIFO_m2u_pushflag,
    output logic                 Interrupt_o
);

    // Handshake: a request is CYC&STB sampled while ACK is low; ACK is the
    // one-cycle ready/done strobe and carries read data. The master must
    // hold address/data stable until it sees ACK.
    logic wb_req, wr_req, rd_req;
    logic hit_rx, hit_tx, hit_st, hit_ctrl, hit_to;

    assign wb_req = WBs_CYC_i & WBs_STB_i & ~WBs_ACK_o;
    assign wr_req = wb_req & WBs_WE_i;
    assign rd_req = wb_req & ~WBs_WE_i;

    assign hit_rx   = (WBs_ADR_i == ADDRWIDTH'(ADR_RX_DATA));
    assign hit_tx   = (WBs_ADR_i == ADDRWIDTH'(ADR_TX_DATA));
    assign hit_st   = (WBs_ADR_i == ADDRWIDTH'(ADR_STATUS));
    assign hit_ctrl = (WBs_ADR_i == ADDRWIDTH'(ADR_CTRL));
    assign hit_to   = (WBs_ADR_i == ADDRWIDTH'(ADR_TIMEOUT));

    logic                 rx_irq_en, tx_irq_en;
    logic [3:0]           rx_thresh, tx_thresh;
    logic [TIMEOUT_W-1:0] timeout;
    logic                 tx_ovf, rx_pend, tx_pend;
    logic                 rd_consume_q, rx_consume;
    rx_state_e            rx_state;
    logic                 rx_valid;
    logic [7:0]           rx_byte;
    logic                 idle_hit;

    usb_serial_rx_prefetch #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_rx_prefetch (
        .clk        (WBs_CLK_i),
        .rst_n      (WBs_RST_n_i),
        .fifo_empty (FIFO_u2m_empty),
        .fifo_pop   (FIFO_u2m_pop),
        .fifo_dout  (FIFO_u2m_dout),
        .popflag    (FIFO_u2m_popflag),
        .consume    (rx_consume),
        .timeout    (timeout),
        .state      (rx_state),
        .rx_byte    (rx_byte),
        .idle_hit   (idle_hit)
    );

    assign rx_valid   = (rx_state == RX_HOLD);
    assign rx_consume = WBs_ACK_o & rd_consume_q;

    logic [31:0] status_word, rd_data, wmask, to_merge;
    logic        unused_bits;

    assign status_word = {19'd0, tx_pend, rx_pend, tx_ovf, FIFO_m2u_full, rx_valid,
                          FIFO_m2u_pushflag, FIFO_u2m_popflag};
    assign wmask       = byte_mask(WBs_BYTE_STB_i);
    assign to_merge    = (32'(timeout) & ~wmask) | (WBs_DAT_i & wmask);
    assign unused_bits = ^{to_merge, WBs_DAT_i, WBs_BYTE_STB_i};

    always_comb begin
        rd_data = DEF_REG_VALUE;
        if (hit_rx) begin
            rd_data = rx_valid ? {23'd0, 1'b1, rx_byte} : 32'd0;
        end else if (hit_tx) begin
            rd_data = 32'd0;
        end else if (hit_st) begin
            rd_data = status_word;
        end else if (hit_ctrl) begin
            rd_data = {20'd0, tx_thresh, rx_thresh, 2'b00, tx_irq_en, rx_irq_en};
        end else if (hit_to) begin
            rd_data = 32'(timeout);
        end
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            WBs_ACK_o    <= 1'b0;
            WBs_DAT_o    <= 32'd0;
            rd_consume_q <= 1'b0;
        end else begin
            WBs_ACK_o    <= wb_req;
            WBs_DAT_o    <= rd_req ? rd_data : 32'd0;
            rd_consume_q <= rd_req & hit_rx & rx_valid;
        end
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            rx_irq_en <= 1'b0;
            tx_irq_en <= 1'b0;
            rx_thresh <= RX_THRESH_DEF;
            tx_thresh <= TX_THRESH_DEF;
            timeout   <= TIMEOUT_DEF;
        end else if (wr_req) begin
            if (hit_ctrl && WBs_BYTE_STB_i[0]) begin
                rx_irq_en <= WBs_DAT_i[CTRL_RX_IRQ_EN];
                tx_irq_en <= WBs_DAT_i[CTRL_TX_IRQ_EN];
                rx_thresh <= WBs_DAT_i[7:4];
            end
            if (hit_ctrl && WBs_BYTE_STB_i[1]) begin
                tx_thresh <= WBs_DAT_i[11:8];
            end
            if (hit_to) begin
                timeout <= to_merge[TIMEOUT_W-1:0];
            end
        end
    end

    logic tx_wr, st_w1c, rx_set, tx_set;

    assign tx_wr  = wr_req & hit_tx & WBs_BYTE_STB_i[0];
    assign st_w1c = wr_req & hit_st & WBs_BYTE_STB_i[1];
    assign rx_set = rx_irq_en & ((FIFO_u2m_popflag >= rx_thresh) | idle_hit);
    assign tx_set = tx_irq_en & (FIFO_m2u_pushflag >= tx_thresh);

    // Set terms are ORed in after the clear so a still-true condition re-arms the bit.
    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            FIFO_m2u_push <= 1'b0;
            FIFO_m2u_din  <= 8'd0;
            tx_ovf        <= 1'b0;
            rx_pend       <= 1'b0;
            tx_pend       <= 1'b0;
            Interrupt_o   <= 1'b0;
        end else begin
            FIFO_m2u_push <= tx_wr & ~FIFO_m2u_full;
            if (tx_wr && !FIFO_m2u_full) begin
                FIFO_m2u_din <= WBs_DAT_i[7:0];
            end
            tx_ovf  <= (tx_ovf  & ~(st_w1c & WBs_DAT_i[ST_TX_OVF]))  | (tx_wr & FIFO_m2u_full);
            rx_pend <= (rx_pend & ~(st_w1c & WBs_DAT_i[ST_RX_PEND])) | rx_set;
            tx_pend <= (tx_pend & ~(st_w1c & WBs_DAT_i[ST_TX_PEND])) | tx_set;
            Interrupt_o <= rx_pend | tx_pend;
        end
    end

endmodule
